// File: rtl/cpu_pkg.sv
// Shared definitions for the 5-stage pipeline: PC source codes,
// bubble word and IF-stage state encoding.
package cpu_pkg;

    localparam logic [1:0] PCS_SEQ = 2'b00;
    localparam logic [1:0] PCS_BR  = 2'b01;
    localparam logic [1:0] PCS_JR  = 2'b10;
    localparam logic [1:0] PCS_J   = 2'b11;

    localparam logic [31:0] NOP_INST = 32'h0000_0000;

    localparam logic [0:0] ST_RUN = 1'b0;
    localparam logic [0:0] ST_RDR = 1'b1;

endpackage

// File: rtl/mux4x32.sv
// 4-to-1 32-bit multiplexer cell.
module mux4x32 (
    input  logic [31:0] d0,
    input  logic [31:0] d1,
    input  logic [31:0] d2,
    input  logic [31:0] d3,
    input  logic [1:0]  s,
    output logic [31:0] y
);

    always_comb begin
        unique case (s)
            2'b00:   y = d0;
            2'b01:   y = d1;
            2'b10:   y = d2;
            default: y = d3;
        endcase
    end

endmodule

// File: rtl/pipe_if_stage.sv
// Instruction fetch stage with IF/ID pipeline register, MIPS delay slot,
// ready-handshaked instruction memory and pending-redirect holding.
module pipe_if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [1:0]  pcsource,
    input  logic [31:0] bpc,
    input  logic [31:0] da,
    input  logic [31:0] jpc,
    input  logic        wpcir,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] pc,
    output logic [31:0] dpc4,
    output logic [31:0] inst,
    output logic        inst_valid
);

    import cpu_pkg::*;

    logic [31:0] pc4;
    logic [31:0] npc;
    logic [31:0] rpc;
    logic [0:0]  state;
    logic        redirect;

    assign pc4       = pc + 32'd4;
    assign imem_addr = pc;
    assign redirect  = wpcir & (pcsource != PCS_SEQ);

    mux4x32 u_npc_mux (
        .d0 (pc4),
        .d1 (bpc),
        .d2 (da),
        .d3 (jpc),
        .s  (pcsource),
        .y  (npc)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pc         <= RESET_PC;
            rpc        <= RESET_PC;
            inst       <= NOP_INST;
            dpc4       <= 32'h0;
            inst_valid <= 1'b0;
            state      <= ST_RUN;
        end else if (wpcir) begin
            if (imem_ready) begin
                inst       <= imem_rdata;
                dpc4       <= pc4;
                inst_valid <= 1'b1;
                pc         <= (state == ST_RDR) ? rpc : npc;
                state      <= ST_RUN;
            end else begin
                inst       <= NOP_INST;
                inst_valid <= 1'b0;
                // Outstanding fetch is the delay slot; park the target.
                if (redirect && state == ST_RUN) begin
                    rpc   <= npc;
                    state <= ST_RDR;
                end
            end
        end
    end

    // ID holds a bubble while a redirect is pending, so none may arrive.
    a_no_double_redirect : assert property (
        @(posedge clock) disable iff (!resetn)
        !(state == ST_RDR && wpcir && imem_ready && redirect)
    );

endmodule
